// File: rtl/kmp_ff_gen_if.sv
// Pattern-in / failure-table-out bundle between the pattern source, the KMP
// failure-function generator and the PE array.
interface kmp_ff_gen_if #(
    parameter int unsigned MAX_PATTERN = 8,
    parameter int unsigned BYTE        = 8,
    parameter int unsigned FF_W        = 4,
    parameter int unsigned LEN_W       = 4
) ();

    logic [MAX_PATTERN*BYTE-1:0] pat_input;
    logic [LEN_W-1:0]            pat_len;
    logic                        input_valid;
    logic                        in_ready;
    logic                        out_ready;
    logic                        ff_valid;
    logic [MAX_PATTERN*FF_W-1:0] ff_result;
    logic [MAX_PATTERN*BYTE-1:0] pat_out;
    logic [LEN_W-1:0]            len_out;

    modport master (
        output pat_input,
        output pat_len,
        output input_valid,
        output out_ready,
        input  in_ready,
        input  ff_valid,
        input  ff_result,
        input  pat_out,
        input  len_out
    );

    modport slave (
        input  pat_input,
        input  pat_len,
        input  input_valid,
        input  out_ready,
        output in_ready,
        output ff_valid,
        output ff_result,
        output pat_out,
        output len_out
    );

endinterface

// File: rtl/kmp_ff_gen.sv
// KMP failure-function generator: captures one pattern, computes ff[] with one
// character comparison per cycle, then holds the table until downstream accepts it.
module kmp_ff_gen #(
    parameter int unsigned MAX_PATTERN = 8,
    parameter int unsigned BYTE        = 8,
    parameter int unsigned FF_W        = 4,
    parameter int unsigned LEN_W       = 4
) (
    input  logic         clk,
    input  logic         reset,
    kmp_ff_gen_if.slave  bus
);

    localparam int unsigned IdxW = (MAX_PATTERN > 1) ? $clog2(MAX_PATTERN) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [BYTE-1:0] pat_q [MAX_PATTERN];
    logic [BYTE-1:0] pat_d [MAX_PATTERN];
    logic [FF_W-1:0] ff_q  [MAX_PATTERN];
    logic [FF_W-1:0] ff_d  [MAX_PATTERN];
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] i_q, i_d;
    logic [FF_W-1:0]  j_q, j_d;

    logic [FF_W-1:0] j_inc;
    logic [IdxW-1:0] i_idx, jn_idx, jb_idx;
    logic            last_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            len_q   <= '0;
            i_q     <= '0;
            j_q     <= '1;
            for (int k = 0; k < MAX_PATTERN; k++) begin
                pat_q[k] <= '0;
                ff_q[k]  <= '1;
            end
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            i_q     <= i_d;
            j_q     <= j_d;
            for (int k = 0; k < MAX_PATTERN; k++) begin
                pat_q[k] <= pat_d[k];
                ff_q[k]  <= ff_d[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        i_d     = i_q;
        j_d     = j_q;
        for (int k = 0; k < MAX_PATTERN; k++) begin
            pat_d[k] = pat_q[k];
            ff_d[k]  = ff_q[k];
        end

        // j == -1 wraps to index 0, which is exactly the p[j+1] we want
        j_inc     = j_q + FF_W'(1);
        i_idx     = i_q[IdxW-1:0];
        jn_idx    = j_inc[IdxW-1:0];
        jb_idx    = j_q[IdxW-1:0];
        last_step = (i_q + LEN_W'(1)) == len_q;

        unique case (state_q)
            StIdle: begin
                if (bus.input_valid) begin
                    for (int k = 0; k < MAX_PATTERN; k++) begin
                        pat_d[k] = bus.pat_input[k*BYTE +: BYTE];
                        ff_d[k]  = '1;
                    end
                    len_d   = (bus.pat_len > LEN_W'(MAX_PATTERN)) ? LEN_W'(MAX_PATTERN)
                                                                  : bus.pat_len;
                    i_d     = LEN_W'(1);
                    j_d     = '1;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (i_q >= len_q) begin
                    state_d = StDone;
                end else if (pat_q[jn_idx] == pat_q[i_idx]) begin
                    ff_d[i_idx] = j_inc;
                    j_d         = j_inc;
                    i_d         = i_q + LEN_W'(1);
                    if (last_step) state_d = StDone;
                end else if (j_q == '1) begin
                    ff_d[i_idx] = '1;
                    i_d         = i_q + LEN_W'(1);
                    if (last_step) state_d = StDone;
                end else begin
                    // Fall back along the failure chain; i stays put
                    j_d = ff_q[jb_idx];
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.ff_valid  = (state_q == StDone);
        bus.len_out   = len_q;
        bus.ff_result = '0;
        bus.pat_out   = '0;
        for (int k = 0; k < MAX_PATTERN; k++) begin
            bus.ff_result[k*FF_W +: FF_W] = ff_q[k];
            bus.pat_out[k*BYTE +: BYTE]   = pat_q[k];
        end
    end

endmodule

// File: tb/tb_kmp_ff_gen.sv
// Directed bench for kmp_ff_gen: table of patterns with hand-computed failure
// tables and step counts, plus backpressure and mid-job reset sequences.
module tb_kmp_ff_gen;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    kmp_ff_gen_if #(.MAX_PATTERN(8), .BYTE(8), .FF_W(4), .LEN_W(4)) bus ();

    kmp_ff_gen #(.MAX_PATTERN(8), .BYTE(8), .FF_W(4), .LEN_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0] pat;
        logic [3:0]  len;
        logic [31:0] ff;
        int          steps;
        logic [3:0]  len_out;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk_pat(input string s);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < s.len() && k < 8; k++) r[k*8 +: 8] = s[k];
        return r;
    endfunction

    // Returns at the negedge right after the accept edge
    task automatic start_job(input logic [63:0] p, input logic [3:0] l);
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        bus.pat_input   = p;
        bus.pat_len     = l;
        bus.input_valid = 1'b1;
        @(negedge clk);
        bus.input_valid = 1'b0;
    endtask

    // Edges after the accept edge until ff_valid is seen
    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.ff_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic release_done();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("idle_ff_valid", 64'(bus.ff_valid), 64'd0);
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset           = 1'b1;
        bus.pat_input   = '0;
        bus.pat_len     = '0;
        bus.input_valid = 1'b0;
        bus.out_ready   = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_ff_valid", 64'(bus.ff_valid), 64'd0);
        check("rst_ff_result", 64'(bus.ff_result), 64'hFFFF_FFFF);
        check("rst_pat_out", bus.pat_out, 64'd0);
        check("rst_len_out", 64'(bus.len_out), 64'd0);
        reset = 1'b0;

        vecs[0] = '{mk_pat("AAAA"),     4'd4,  32'hFFFF_210F, 3, 4'd4};
        vecs[1] = '{mk_pat("ABAB"),     4'd4,  32'hFFFF_10FF, 3, 4'd4};
        vecs[2] = '{mk_pat("AAAB"),     4'd4,  32'hFFFF_F10F, 5, 4'd4};
        vecs[3] = '{mk_pat("QR"),       4'd0,  32'hFFFF_FFFF, 1, 4'd0};
        vecs[4] = '{mk_pat("Z"),        4'd1,  32'hFFFF_FFFF, 1, 4'd1};
        vecs[5] = '{mk_pat("AAAAAAAA"), 4'd12, 32'h6543_210F, 7, 4'd8};
        vecs[6] = '{mk_pat("ABACABAB"), 4'd8,  32'h1210_F0FF, 9, 4'd8};

        for (int v = 0; v < 7; v++) begin
            start_job(vecs[v].pat, vecs[v].len);
            wait_valid(n);
            check($sformatf("v%0d_valid_cycle", v), 64'(1 + n), 64'(1 + vecs[v].steps));
            check($sformatf("v%0d_ff_result", v), 64'(bus.ff_result), 64'(vecs[v].ff));
            check($sformatf("v%0d_len_out", v), 64'(bus.len_out), 64'(vecs[v].len_out));
            check($sformatf("v%0d_pat_out", v), bus.pat_out, vecs[v].pat);
            check($sformatf("v%0d_in_ready_done", v), 64'(bus.in_ready), 64'd0);
            release_done();
        end

        // Backpressure: table held, second pattern waits for in_ready
        start_job(mk_pat("AAAA"), 4'd4);
        wait_valid(n);
        check("bp_valid_cycle", 64'(1 + n), 64'd4);
        bus.pat_input   = mk_pat("ABAB");
        bus.pat_len     = 4'd4;
        bus.input_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_ff_valid", 64'(bus.ff_valid), 64'd1);
            check("bp_ff_result", 64'(bus.ff_result), 64'hFFFF_210F);
            check("bp_pat_out", bus.pat_out, mk_pat("AAAA"));
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_idle_in_ready", 64'(bus.in_ready), 64'd1);
        check("bp_idle_ff_valid", 64'(bus.ff_valid), 64'd0);
        @(negedge clk);
        bus.input_valid = 1'b0;
        check("bp_second_accepted", 64'(bus.in_ready), 64'd0);
        wait_valid(n);
        check("bp_second_cycle", 64'(1 + n), 64'd4);
        check("bp_second_ff", 64'(bus.ff_result), 64'hFFFF_10FF);
        check("bp_second_pat", bus.pat_out, mk_pat("ABAB"));
        release_done();

        // Reset on the second CALC cycle aborts the job
        start_job(mk_pat("AAAB"), 4'd4);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_ff_valid", 64'(bus.ff_valid), 64'd0);
        check("abort_ff_result", 64'(bus.ff_result), 64'hFFFF_FFFF);
        check("abort_len_out", 64'(bus.len_out), 64'd0);
        check("abort_pat_out", bus.pat_out, 64'd0);
        start_job(mk_pat("ABAB"), 4'd4);
        wait_valid(n);
        check("abort_next_cycle", 64'(1 + n), 64'd4);
        check("abort_next_ff", 64'(bus.ff_result), 64'hFFFF_10FF);
        check("abort_next_len", 64'(bus.len_out), 64'd4);
        release_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
